// File: rtl/stream_window_hasher.sv
// Streaming MinHash sketcher: builds K-mers from a 2-bit base stream and emits,
// per non-overlapping window, the bucketed minimum of each salted hash.
module stream_window_hasher #(
  parameter int unsigned SKETCH_SIZE         = 16,
  parameter int unsigned NUM_OF_BUCKETS      = 256,
  parameter int unsigned LOG2_NUM_OF_BUCKETS = 8,
  parameter int unsigned WINDOW_SIZE         = 128,
  parameter int unsigned KMER_SIZE           = 16,
  parameter int unsigned HASH_W              = 2 * KMER_SIZE,
  parameter logic [HASH_W-1:0] HASH_MULT     = HASH_W'(32'h9E3779B1),
  parameter logic [HASH_W-1:0] SALT_STEP     = HASH_W'(32'h7F4A7C15),
  parameter int unsigned WIN_CNT_W           = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1:0]                     in_base,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LOG2_NUM_OF_BUCKETS-1:0] hashedSketch [0:SKETCH_SIZE-1],
  output logic [WIN_CNT_W-1:0]           out_window_idx
);

  localparam int unsigned KMER_W = 2 * KMER_SIZE;
  localparam int unsigned CNT_W  = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1;
  localparam int unsigned LB     = LOG2_NUM_OF_BUCKETS;

  if ((NUM_OF_BUCKETS != (32'd1 << LOG2_NUM_OF_BUCKETS)) || (LB > HASH_W) ||
      (WINDOW_SIZE < KMER_SIZE) || (KMER_SIZE < 2)) begin : g_bad_cfg
    $error("stream_window_hasher: inconsistent parameter set");
  end

  logic [KMER_W-1:0]    r_kmer;
  logic [CNT_W-1:0]     r_base_cnt;
  logic                 r_s2_valid;
  logic                 r_s2_last;
  logic [HASH_W-1:0]    r_hash   [SKETCH_SIZE];
  logic                 r_h_valid;
  logic                 r_h_last;
  logic [HASH_W-1:0]    r_min    [SKETCH_SIZE];
  logic [LB-1:0]        r_sketch [SKETCH_SIZE];
  logic                 r_out_valid;
  logic [WIN_CNT_W-1:0] r_out_idx;
  logic [WIN_CNT_W-1:0] r_win_cnt;

  logic [HASH_W-1:0]    w_hash   [SKETCH_SIZE];
  logic [HASH_W-1:0]    w_newmin [SKETCH_SIZE];
  logic                 w_stall;
  logic                 w_accept;
  logic                 w_commit;
  logic                 w_cnt_last;

  // A window-final minimum can only retire into an empty or draining output register.
  assign w_stall    = r_h_valid && r_h_last && r_out_valid && !out_ready;
  assign w_commit   = r_h_valid && r_h_last && !w_stall;
  assign in_ready   = !w_stall;
  assign w_accept   = in_valid && in_ready;
  assign w_cnt_last = (r_base_cnt == CNT_W'(WINDOW_SIZE - 1));

  for (genvar g = 0; g < SKETCH_SIZE; g++) begin : g_slot
    localparam logic [HASH_W-1:0] SALT = HASH_W'(HASH_W'(g) * SALT_STEP);
    assign w_hash[g]   = (HASH_W'(r_kmer) ^ SALT) * HASH_MULT;
    assign w_newmin[g] = (r_hash[g] < r_min[g]) ? r_hash[g] : r_min[g];
  end

  // K-mer build, registered hash stage and running minima; everything freezes on stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kmer     <= '0;
      r_base_cnt <= '0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_h_valid  <= 1'b0;
      r_h_last   <= 1'b0;
      for (int i = 0; i < SKETCH_SIZE; i++) begin
        r_hash[i] <= '0;
        r_min[i]  <= '1;
      end
    end else if (!w_stall) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      if (w_accept) begin
        r_kmer     <= (r_base_cnt == '0) ? KMER_W'(in_base) : {r_kmer[KMER_W-3:0], in_base};
        r_base_cnt <= w_cnt_last ? '0 : r_base_cnt + CNT_W'(1);
        r_s2_valid <= (r_base_cnt >= CNT_W'(KMER_SIZE - 1));
        r_s2_last  <= w_cnt_last;
      end
      r_h_valid <= r_s2_valid;
      r_h_last  <= r_s2_last;
      if (r_s2_valid) begin
        for (int i = 0; i < SKETCH_SIZE; i++) r_hash[i] <= w_hash[i];
      end
      if (r_h_valid) begin
        for (int i = 0; i < SKETCH_SIZE; i++) r_min[i] <= r_h_last ? '1 : w_newmin[i];
      end
    end
  end

  // Output sketch register; reloads in the same cycle it drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_win_cnt   <= '0;
      for (int i = 0; i < SKETCH_SIZE; i++) r_sketch[i] <= '0;
    end else if (w_commit) begin
      r_out_valid <= 1'b1;
      r_out_idx   <= r_win_cnt;
      r_win_cnt   <= r_win_cnt + WIN_CNT_W'(1);
      for (int i = 0; i < SKETCH_SIZE; i++) r_sketch[i] <= w_newmin[i][HASH_W-1 -: LB];
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid      = r_out_valid;
  assign out_window_idx = r_out_idx;
  for (genvar g = 0; g < SKETCH_SIZE; g++) begin : g_out
    assign hashedSketch[g] = r_sketch[g];
  end

endmodule

// File: tb/tb_stream_window_hasher.sv
// Bench for stream_window_hasher: a tiny configuration with hand-computed
// vectors plus the default configuration against a behavioural sketch model.
module tb_stream_window_hasher;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [1:0] s_in_base;
  logic [1:0] s_sketch [0:1];
  logic [15:0] s_idx;

  logic       d_in_valid, d_in_ready, d_out_valid, d_out_ready;
  logic [1:0] d_in_base;
  logic [7:0] d_sketch [0:15];
  logic [15:0] d_idx;

  int n_cmp = 0;
  int n_bad = 0;
  int s_rdy_drops = 0;

  stream_window_hasher #(
    .SKETCH_SIZE(2), .NUM_OF_BUCKETS(4), .LOG2_NUM_OF_BUCKETS(2), .WINDOW_SIZE(4),
    .KMER_SIZE(2), .HASH_W(4), .HASH_MULT(4'h1), .SALT_STEP(4'h8), .WIN_CNT_W(16)
  ) u_small (
    .clk(clk), .reset(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_base(s_in_base), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .hashedSketch(s_sketch), .out_window_idx(s_idx)
  );

  stream_window_hasher u_def (
    .clk(clk), .reset(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_base(d_in_base), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .hashedSketch(d_sketch), .out_window_idx(d_idx)
  );

  typedef struct packed {
    logic [7:0] bases;  // first base in [7:6]
    logic [1:0] e0;
    logic [1:0] e1;
  } vec_t;
  vec_t tbl [8];

  logic [19:0]  cap_q [$];
  logic [143:0] exp_q [$];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] model_win(input logic [1:0] b [128]);
    logic [31:0] km, h, salt;
    logic [31:0] mn [16];
    logic [127:0] r;
    km = '0;
    for (int i = 0; i < 16; i++) mn[i] = '1;
    for (int p = 0; p < 128; p++) begin
      km = (p == 0) ? {30'd0, b[p]} : {km[29:0], b[p]};
      if (p >= 15) begin
        for (int i = 0; i < 16; i++) begin
          salt = 32'(i) * 32'h7F4A7C15;
          h = (km ^ salt) * 32'h9E3779B1;
          if (h < mn[i]) mn[i] = h;
        end
      end
    end
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = mn[i][31:24];
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && s_out_valid && s_out_ready)
      cap_q.push_back({s_idx, s_sketch[0], s_sketch[1]});
  end

  always @(negedge clk) begin
    logic [127:0] act;
    logic [143:0] e;
    if (!rst && d_out_valid && d_out_ready) begin
      for (int i = 0; i < 16; i++) act[i*8 +: 8] = d_sketch[i];
      if (exp_q.size() == 0) begin
        check("d_unexpected_out", {d_idx, act}, '0);
      end else begin
        e = exp_q.pop_front();
        check("d_sketch", {d_idx, act}, e);
      end
    end
  end

  task automatic do_reset();
    s_in_valid = 1'b0; d_in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cap_q.delete();
  endtask

  task automatic s_send(input logic [1:0] b);
    bit acc = 1'b0;
    s_in_valid = 1'b1; s_in_base = b;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = s_in_ready;
      if (!acc) s_rdy_drops++;
      @(posedge clk); #1;
    end
    if (!acc) check("s_send_timeout", 0, 1);
  endtask

  task automatic s_window(input logic [7:0] bases);
    for (int k = 0; k < 4; k++) s_send(bases[7-2*k -: 2]);
  endtask

  task automatic d_send(input logic [1:0] b);
    bit acc = 1'b0;
    d_in_valid = 1'b1; d_in_base = b;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = d_in_ready;
      @(posedge clk); #1;
      d_out_ready = ($urandom_range(3, 0) != 0);
    end
    if (!acc) check("d_send_timeout", 0, 1);
  endtask

  task automatic wait_caps(input int n, input string name);
    for (int t = 0; t < 50 && cap_q.size() < n; t++) @(posedge clk);
    #1 check(name, cap_q.size(), n);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    logic [1:0] win [128];
    tbl[0] = '{8'b01_00_00_11, 2'd0, 2'd2};
    tbl[1] = '{8'b11_11_11_11, 2'd3, 2'd1};
    tbl[2] = '{8'b10_01_11_00, 2'd1, 2'd0};
    tbl[3] = '{8'b00_00_00_00, 2'd0, 2'd2};
    tbl[4] = '{8'b01_01_01_01, 2'd1, 2'd3};
    tbl[5] = '{8'b10_11_11_01, 2'd2, 2'd0};
    tbl[6] = '{8'b01_01_10_10, 2'd1, 2'd0};
    tbl[7] = '{8'b11_10_01_00, 2'd1, 2'd0};
    s_in_base = 2'd0; d_in_base = 2'd0; s_out_ready = 1'b1; d_out_ready = 1'b1;

    // Reset state and single-window latency
    do_reset();
    @(negedge clk);
    check("rst_out_valid", s_out_valid, 0);
    check("rst_in_ready", s_in_ready, 1);
    check("rst_sketch_idx", {s_idx, s_sketch[0], s_sketch[1]}, 0);
    check("rst_def_state", {d_out_valid, d_in_ready, d_idx}, {1'b0, 1'b1, 16'd0});
    @(posedge clk); #1;
    s_window(tbl[0].bases);
    s_in_valid = 1'b0;
    @(negedge clk); check("t1_valid_e0", s_out_valid, 0);
    @(negedge clk); check("t1_valid_e1", s_out_valid, 0);
    @(negedge clk); check("t1_valid_e2", s_out_valid, 1);
    check("t1_sketch", {s_idx, s_sketch[0], s_sketch[1]}, {16'd0, 2'd0, 2'd2});
    @(negedge clk); check("t1_valid_e3", s_out_valid, 0);

    // Continuous stream of table windows
    do_reset();
    s_rdy_drops = 0;
    for (int v = 0; v < 8; v++) s_window(tbl[v].bases);
    s_in_valid = 1'b0;
    check("t2_in_ready_drops", s_rdy_drops, 0);
    wait_caps(8, "t2_capture_count");
    for (int v = 0; v < 8; v++) begin
      if (v < cap_q.size())
        check($sformatf("t2_win%0d", v), cap_q[v], {16'(v), tbl[v].e0, tbl[v].e1});
    end

    // Backpressure: window 0 held while window 1 completes
    do_reset();
    s_out_ready = 1'b0;
    s_window(tbl[0].bases);
    s_window(tbl[1].bases);
    s_in_valid = 1'b0;
    @(negedge clk);
    check("t3_ready_before", s_in_ready, 1);
    check("t3_held_a", {s_out_valid, s_idx, s_sketch[0], s_sketch[1]}, {1'b1, 16'd0, 2'd0, 2'd2});
    @(negedge clk);
    check("t3_ready_drop", s_in_ready, 0);
    repeat (3) @(negedge clk);
    check("t3_still_held", {s_in_ready, s_out_valid, s_idx, s_sketch[0], s_sketch[1]},
          {1'b0, 1'b1, 16'd0, 2'd0, 2'd2});
    @(posedge clk); #1 s_out_ready = 1'b1;
    @(negedge clk);
    check("t3_ready_release", s_in_ready, 1);
    @(negedge clk);
    check("t3_loaded_b", {s_out_valid, s_idx, s_sketch[0], s_sketch[1]}, {1'b1, 16'd1, 2'd3, 2'd1});
    @(negedge clk);
    check("t3_drained", s_out_valid, 0);
    check("t3_caps", cap_q.size(), 2);
    if (cap_q.size() == 2) check("t3_cap_a", cap_q[0], {16'd0, 2'd0, 2'd2});

    // Random input bubbles on the first vector
    do_reset();
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < 6 && $urandom_range(1, 0) == 1; g++) begin
        s_in_valid = 1'b0; s_in_base = 2'($urandom_range(3, 0));
        @(posedge clk); #1;
      end
      if (k == 3) check("t4_no_early_valid", {s_out_valid, 8'(cap_q.size())}, 0);
      s_send(tbl[0].bases[7-2*k -: 2]);
    end
    s_in_valid = 1'b0;
    wait_caps(1, "t4_capture_count");
    if (cap_q.size() > 0) check("t4_sketch", cap_q[0], {16'd0, 2'd0, 2'd2});

    // Reset mid-window discards partial minima (2,0 would drive slot 1 to bucket 0)
    do_reset();
    s_send(2'd2); s_send(2'd0);
    s_in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    do_reset();
    s_window(tbl[0].bases);
    s_in_valid = 1'b0;
    wait_caps(1, "t5_capture_count");
    if (cap_q.size() > 0) check("t5_sketch", cap_q[0], {16'd0, 2'd0, 2'd2});
    repeat (5) @(posedge clk); #1;
    check("t5_single_output", cap_q.size(), 1);

    // Default configuration against the model, random bubbles and backpressure
    do_reset();
    for (int w = 0; w < 200; w++) begin
      for (int p = 0; p < 128; p++) win[p] = 2'($urandom_range(3, 0));
      exp_q.push_back({16'(w), model_win(win)});
      for (int p = 0; p < 128; p++) begin
        for (int g = 0; g < 3 && $urandom_range(9, 0) == 0; g++) begin
          d_in_valid = 1'b0;
          d_out_ready = ($urandom_range(3, 0) != 0);
          @(posedge clk); #1;
        end
        d_send(win[p]);
      end
    end
    d_in_valid = 1'b0; d_out_ready = 1'b1;
    for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(posedge clk);
    #1 check("t6_all_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
